// File: rtl/waveforms_plot_sequencer.sv
// rtl/waveforms_plot_sequencer.sv - frame sequencer driving the SSD1306 waveform plotter registers
module waveforms_plot_sequencer #(
    parameter int NUM_PAGES      = 8,
    parameter int BYTES_PER_PAGE = 15,
    parameter bit INIT_EN        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] presc,
    input  logic       gnd_en,
    input  logic       header_en,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    output logic       sample_ready,
    output logic [3:0] p_address,
    output logic       p_data_write,
    output logic [7:0] p_data_in,
    input  logic       p_idle,
    output logic       busy,
    output logic       done,
    output logic [2:0] page
);

    localparam logic [3:0] ADDR_DATA     = 4'h0;
    localparam logic [3:0] ADDR_SPI      = 4'h1;
    localparam logic [3:0] ADDR_DC_PRESC = 4'h2;
    localparam logic [3:0] ADDR_SEL      = 4'h8;
    localparam logic [2:0] LAST_PAGE     = 3'(NUM_PAGES - 1);
    localparam logic [3:0] LAST_BYTE     = 4'(BYTES_PER_PAGE - 1);
    localparam logic [2:0] LAST_INIT     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_INIT,
        S_SEL,
        S_FETCH,
        S_DATA,
        S_END
    } state_t;

    // Every command state walks ISSUE -> GAP -> WAIT; the gap covers the plotter's late status.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_GAP,
        PH_WAIT
    } phase_t;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [2:0] init_q, init_d;
    logic [3:0] byte_q, byte_d;
    logic [2:0] page_q, page_d;
    logic [3:0] presc_q, presc_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pop;
    logic       go_sel, go_end;
    logic [2:0] sel_page;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'hAE;
            3'd1:    init_byte = 8'h20;
            3'd2:    init_byte = 8'h02;
            3'd3:    init_byte = 8'h8D;
            3'd4:    init_byte = 8'h14;
            default: init_byte = 8'hAF;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        init_d   = init_q;
        byte_d   = byte_q;
        page_d   = page_q;
        presc_d  = presc_q;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        go_sel   = 1'b0;
        go_end   = 1'b0;
        sel_page = page_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    presc_d = presc;
                    page_d  = 3'd0;
                    byte_d  = 4'd0;
                    init_d  = 3'd0;
                    state_d = S_CFG;
                    phase_d = PH_ISSUE;
                    addr_d  = ADDR_DC_PRESC;
                    // header/ground enables only appear here, so the command register holds them
                    data_d  = {header_en, gnd_en, 2'b00, presc};
                end
            end
            S_FETCH: begin
                if (abort) begin
                    go_end = 1'b1;
                end else if (sample_valid) begin
                    pop     = 1'b1;
                    state_d = S_DATA;
                    phase_d = PH_ISSUE;
                    addr_d  = ADDR_DATA;
                    data_d  = sample_data;
                end
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: phase_d = PH_GAP;
                    PH_GAP:   phase_d = PH_WAIT;
                    default: begin
                        if (p_idle) begin
                            phase_d = PH_ISSUE;
                            if (state_q == S_END) begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else if (abort) begin
                                go_end = 1'b1;
                            end else begin
                                case (state_q)
                                    S_CFG: begin
                                        if (INIT_EN) begin
                                            state_d = S_INIT;
                                            init_d  = 3'd0;
                                            addr_d  = ADDR_SPI;
                                            data_d  = init_byte(3'd0);
                                        end else begin
                                            go_sel = 1'b1;
                                        end
                                    end
                                    S_INIT: begin
                                        if (init_q == LAST_INIT) begin
                                            go_sel = 1'b1;
                                        end else begin
                                            init_d = init_q + 3'd1;
                                            data_d = init_byte(init_q + 3'd1);
                                        end
                                    end
                                    S_SEL: state_d = S_FETCH;
                                    S_DATA: begin
                                        if (byte_q < LAST_BYTE) begin
                                            byte_d  = byte_q + 4'd1;
                                            state_d = S_FETCH;
                                        end else if (page_q < LAST_PAGE) begin
                                            go_sel   = 1'b1;
                                            sel_page = page_q + 3'd1;
                                        end else begin
                                            go_end = 1'b1;
                                        end
                                    end
                                    default: state_d = S_IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        endcase

        if (go_sel) begin
            state_d = S_SEL;
            phase_d = PH_ISSUE;
            byte_d  = 4'd0;
            page_d  = sel_page;
            addr_d  = ADDR_SEL;
            data_d  = {5'b0, sel_page};
        end
        // Closing write deselects the panel and drops the header/ground enables.
        if (go_end) begin
            state_d = S_END;
            phase_d = PH_ISSUE;
            addr_d  = ADDR_DC_PRESC;
            data_d  = {2'b00, 2'b11, presc_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= PH_ISSUE;
            init_q  <= 3'd0;
            byte_q  <= 4'd0;
            page_q  <= 3'd0;
            presc_q <= 4'd0;
            addr_q  <= 4'd0;
            data_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            init_q  <= init_d;
            byte_q  <= byte_d;
            page_q  <= page_d;
            presc_q <= presc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign p_data_write = (phase_q == PH_ISSUE) && (state_q != S_IDLE) && (state_q != S_FETCH);
    assign sample_ready = pop;
    assign p_address    = addr_q;
    assign p_data_in    = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign page         = page_q;

endmodule
